// File: rtl/q26_pkg.sv
// Shared format constants and types for the Q1.6 divide-by-3 datapath and its
// BCD display formatter.
package q26_pkg;

  localparam int W_DEF         = 8;
  localparam int FRAC_BITS_DEF = 6;
  localparam int DIGITS        = FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/frac_x10_step.sv
// One decimal digit of a binary fraction: multiply by ten, the overflow above
// the binary point is the digit, the remainder is the next fraction.
module frac_x10_step #(
  parameter int FRAC_BITS = 6
) (
  input  logic [FRAC_BITS-1:0] f_i,
  output logic [3:0]           digit_o,
  output logic [FRAC_BITS-1:0] f_next_o
);

  logic [FRAC_BITS+3:0] f_ext;
  logic [FRAC_BITS+3:0] t;

  assign f_ext    = {4'b0000, f_i};
  // f*10 as two shifts and an add; (2^F-1)*10 < 16*2^F so F+4 bits never overflow
  assign t        = (f_ext << 3) + (f_ext << 1);
  assign digit_o  = t[FRAC_BITS+3:FRAC_BITS];
  assign f_next_o = t[FRAC_BITS-1:0];

endmodule

// File: rtl/q26_bcd_fmt.sv
// Iterative signed fixed-point to sign / integer magnitude / BCD fraction
// converter; one fraction digit per clock behind a start/busy/done handshake.
module q26_bcd_fmt
  import q26_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           in,
  output logic                   busy,
  output logic                   done,
  output logic                   neg,
  output logic [W-FRAC_BITS-1:0] int_val,
  output logic [4*FRAC_BITS-1:0] frac_bcd
);

  localparam int IW    = W - FRAC_BITS;
  localparam int DW    = 4 * FRAC_BITS;
  localparam int CNT_W = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_BITS - 1);

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 neg_q, neg_d;
  logic [IW-1:0]        int_q, int_d;
  logic [DW-1:0]        frac_q, frac_d;

  logic                 sign_q, sign_d;
  logic [IW-1:0]        ipart_q, ipart_d;
  logic [FRAC_BITS-1:0] f_q, f_d;
  logic [DW-1:0]        dig_q, dig_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [W-1:0]         mag;
  bcd_t                 step_digit;
  logic [FRAC_BITS-1:0] step_f_next;

  // Most negative input wraps back to itself, read unsigned it is 2^(W-1)
  assign mag = in[W-1] ? ((~in) + W'(1)) : in;

  frac_x10_step #(
    .FRAC_BITS (FRAC_BITS)
  ) u_step (
    .f_i      (f_q),
    .digit_o  (step_digit),
    .f_next_o (step_f_next)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    int_d   = int_q;
    frac_d  = frac_q;
    sign_d  = sign_q;
    ipart_d = ipart_q;
    f_d     = f_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = in[W-1];
          ipart_d = mag[W-1:FRAC_BITS];
          f_d     = mag[FRAC_BITS-1:0];
          dig_d   = '0;
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        f_d   = step_f_next;
        dig_d = DW'({dig_q, step_digit});
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish only complete results; partial digits never reach the ports
          neg_d   = sign_q;
          int_d   = ipart_q;
          frac_d  = dig_d;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
      sign_q  <= 1'b0;
      ipart_q <= '0;
      f_q     <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      sign_q  <= sign_d;
      ipart_q <= ipart_d;
      f_q     <= f_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign neg      = neg_q;
  assign int_val  = int_q;
  assign frac_bcd = frac_q;

endmodule

// File: tb/tb_q26_bcd_fmt.sv
// Scoreboard bench for q26_bcd_fmt: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_q26_bcd_fmt;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_v;
  logic        busy;
  logic        done;
  logic        neg;
  logic [1:0]  int_val;
  logic [23:0] frac_bcd;

  typedef struct {
    logic        neg;
    logic [1:0]  iv;
    logic [23:0] frac;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  q26_bcd_fmt #(.W(8), .FRAC_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in       (in_v),
    .busy     (busy),
    .done     (done),
    .neg      (neg),
    .int_val  (int_val),
    .frac_bcd (frac_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic n, input logic [1:0] iv, input logic [23:0] fr);
    exp_t e;
    e.neg  = n;
    e.iv   = iv;
    e.frac = fr;
    return e;
  endfunction

  // Reference: |v| split into integer bits and 6-bit fraction; fraction*15625 is the exact 6-digit decimal
  function automatic exp_t model(input logic [7:0] v);
    exp_t        e;
    logic [7:0]  z;
    int          n;
    z      = v[7] ? ((~v) + 8'd1) : v;
    e.neg  = v[7];
    e.iv   = z[7:6];
    n      = int'(z[5:0]) * 15625;
    e.frac = '0;
    for (int i = 0; i < 6; i++) begin
      e.frac[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending conversion (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_neg", 32'(neg), 32'(e.neg));
        check("res_int", 32'(int_val), 32'(e.iv));
        check("res_frac", 32'(frac_bcd), 32'(e.frac));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [7:0] v, input exp_t e);
    wait_idle();
    start = 1'b1;
    in_v  = v;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    in_v  = 8'h5A;
  endtask

  initial begin
    int   cyc;
    int   changed;
    int   d0;
    logic s_neg;
    logic [1:0]  s_int;
    logic [23:0] s_frac;

    rst   = 1'b1;
    start = 1'b0;
    in_v  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_int", 32'(int_val), 32'd0);
    check("rst_frac", 32'(frac_bcd), 32'd0);
    rst = 1'b0;

    // 1: +0.5, busy and latency (edge that samples start counts as clock 1)
    @(negedge clk);
    start = 1'b1;
    in_v  = 8'h20;
    exp_q.push_back(mk(1'b0, 2'd0, 24'h500000));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd7);

    // 2, 3: sign and boundary values
    issue(8'hFF, mk(1'b1, 2'd0, 24'h015625));
    issue(8'h7F, mk(1'b0, 2'd1, 24'h984375));
    issue(8'h80, mk(1'b1, 2'd2, 24'h000000));
    issue(8'h00, mk(1'b0, 2'd0, 24'h000000));
    wait_idle();

    // 4: start held high through CONV/DONE; in changes after acceptance
    start = 1'b1;
    in_v  = 8'h40;
    exp_q.push_back(mk(1'b0, 2'd1, 24'h000000));
    @(negedge clk);
    in_v = 8'hC0;
    exp_q.push_back(mk(1'b1, 2'd1, 24'h000000));
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    s_neg  = neg;
    s_int  = int_val;
    s_frac = frac_bcd;
    d0     = done_cnt;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_start_reaccepted", 32'(busy), 32'd1);
    start = 1'b0;
    changed = 0;
    cyc = 2;
    while (!done && cyc < 20) begin
      if (neg !== s_neg || int_val !== s_int || frac_bcd !== s_frac) changed++;
      @(negedge clk);
      cyc++;
    end
    check("outputs_hold_between", 32'(changed), 32'd0);
    check("restart_spacing", 32'(cyc), 32'd8);
    check("one_done_per_start", 32'(done_cnt - d0), 32'd1);
    wait_idle();

    // 5: reset mid-conversion aborts without done
    start = 1'b1;
    in_v  = 8'h7F;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_neg", 32'(neg), 32'd0);
    check("abort_int", 32'(int_val), 32'd0);
    check("abort_frac", 32'(frac_bcd), 32'd0);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(8'h20, mk(1'b0, 2'd0, 24'h500000));

    // 6: full sweep, back-to-back
    for (int v = 0; v < 256; v++) issue(8'(v), model(8'(v)));
    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q26_bcd_fmt.md
Name: q26_bcd_fmt

Overview:
Downstream display stage for the divide-by-3 block's signed fixed-point result.
- Converts one signed two's-complement value (1 sign bit, 1 integer bit, 6 fraction bits by default) into sign, integer magnitude and FRAC_BITS decimal fraction digits in BCD.
- Sits between the divider output and the display driver.
- Iterative: a start/busy/done handshake, one fraction digit produced per clock.

Parameters:
W, 8, total input width (two's complement)
FRAC_BITS, 6, fraction bits; also the number of decimal fraction digits (exact, since 2^-FRAC_BITS has exactly FRAC_BITS decimals)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request conversion of `in`; sampled only in IDLE
in  in  W  signed value to convert
busy  out  1  high while a conversion is in flight (CONV or DONE)
done  out  1  one-cycle pulse; result outputs valid from this cycle onward
neg  out  1  sign of last converted value
int_val  out  W-FRAC_BITS  integer magnitude (0..2 for W=8)
frac_bcd  out  4*FRAC_BITS  fraction digits; the most significant digit is in the top nibble

Behaviour:
Reset:
- rst high at an edge forces state IDLE and clears busy, done, neg, int_val, frac_bcd and all internal registers.
- Overrides start. Aborting mid-conversion produces no done pulse.

States:
- IDLE, CONV, DONE.

IDLE:
- start=1 at edge E0: latch neg = in[W-1].
- Latch mag = (in[W-1] ? ~in+1 : in), truncated to W bits unsigned. -2^(W-1) maps to 2^(W-1), so int = 2.
- Latch f = mag[FRAC_BITS-1:0], ipart = mag[W-1:FRAC_BITS], cnt = 0. Go to CONV.
- start=0: stay in IDLE; outputs hold.

CONV:
- At each edge: t = f*10 (FRAC_BITS+4 bits). Digit = t >> FRAC_BITS (0..9), shifted into the internal digit register from the low side.
- Then f = t[FRAC_BITS-1:0] and cnt++.
- At edge E_FRAC_BITS (the 6th digit for the default): copy the internal registers to neg/int_val/frac_bcd, set done=1, go to DONE.

DONE:
- Lasts one cycle. The next edge clears done and goes to IDLE.

Latency and throughput:
- done is high in the cycle after edge E0+FRAC_BITS, i.e. FRAC_BITS+1 clocks after start is sampled.
- A new start is first accepted in the IDLE cycle after DONE, so minimum spacing between starts is FRAC_BITS+2 clocks.

Handshake and output rules:
- start while busy (CONV or DONE) is ignored, not queued.
- `in` is only sampled at the accepting edge; changes afterwards have no effect.
- Output registers change only at the done edge. They hold between conversions, so intermediate digits are never visible.
- busy = (state != IDLE) and is registered. It is 0 in the cycle start is presented and 1 from E0 through the DONE cycle.

Arithmetic:
- All digit math is unsigned.
- No rounding is needed; the result is exact.

Decomposition:
- Shared package `q26_pkg`: W and FRAC_BITS defaults, localparam DIGITS = FRAC_BITS, the state enum (IDLE/CONV/DONE), and the BCD nibble typedef. The divider block and its bench reuse the same format constants.
- One combinational sub-module, `frac_x10_step`:
  - Inputs: f.
  - Outputs: digit and next f.
  - Implemented as (f<<3)+(f<<1).
- The FSM, counter and registers stay in q26_bcd_fmt.

Test Plan:
1. After reset, check all outputs 0. Then in=8'h20 with start for 1 clock -> busy=1 the next cycle; done exactly 7 clocks after start sampled; neg=0, int_val=0, frac_bcd=24'h500000.
2. in=8'hFF (-1/64) -> neg=1, int_val=0, frac_bcd=24'h015625. in=8'h7F -> neg=0, int_val=1, frac_bcd=24'h984375.
3. in=8'h80 -> neg=1, int_val=2, frac_bcd=24'h000000. in=8'h00 -> neg=0, int_val=0, frac_bcd=0.
4. start=8'h40 is accepted; hold start=1 with in=8'hC0 through CONV and DONE:
   - The 8'h40 result is reported: int_val=1, frac=0, neg=0.
   - Only one done pulse per accepted start.
   - The second conversion begins in the IDLE cycle after DONE and reports neg=1, int_val=1.
   - Outputs are unchanged between the two done pulses.
5. rst pulsed 3 clocks after start -> no done; outputs 0; busy=0 the next cycle. A subsequent start of 8'h20 converts correctly.
6. Sweep all 256 inputs back-to-back against a reference model computing sign, z[7:6] and z[5:0]*15625 -> every done result matches.
